// File: rtl/fsa_col_extent_pkg.sv
// Shared definitions for the FSA column-extent builder and the mask streamer:
// column BRAM word bit positions and the frame state encoding.
package fsa_pkg;

  // Frame-level states of the column-extent builder.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fsa_state_t;

  // Bottom-row field starts at bit 0 regardless of row-index width.
  localparam int BBIT_B = 0;

  // Last bit of the bottom-row field.
  function automatic int bbit_e(input int hw);
    return hw - 1;
  endfunction

  // First bit of the top-row field.
  function automatic int tbit_b(input int hw);
    return hw;
  endfunction

  // Last bit of the top-row field.
  function automatic int tbit_e(input int hw);
    return 2 * hw - 1;
  endfunction

  // Column-has-foreground flag sits just above the top-row field.
  function automatic int vbit(input int hw);
    return 2 * hw;
  endfunction

endpackage

// File: rtl/fsa_col_extent_if.sv
// AXI-Stream pixel channel feeding the column-extent builder.
interface fsa_col_extent_if #(
  parameter int DW = 8
) ();
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;
  logic [DW-1:0] tdata;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/fsa_col_extent.sv
// Column-extent builder: for each column of a frame, records whether any
// foreground pixel occurred and the first/last foreground rows, using a
// read-modify-write pass over the shared column BRAM.
module fsa_col_extent
  import fsa_pkg::*;
#(
  parameter int C_IMG_HW = 12,
  parameter int C_IMG_WW = 12,
  parameter int C_IN_DW  = 8,
  parameter int BR_DW    = 32,
  parameter int BR_AW    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_IMG_HW-1:0] height,
  input  logic [C_IMG_WW-1:0] width,
  input  logic [C_IMG_WW-1:0] lft_v,
  input  logic [C_IMG_WW-1:0] rt_v,
  input  logic [C_IN_DW-1:0]  th,
  fsa_col_extent_if.slave     s_axis,
  output logic                rd_en,
  output logic [BR_AW-1:0]    rd_addr,
  input  logic [BR_DW-1:0]    rd_data,
  output logic                wr_en,
  output logic [BR_AW-1:0]    wr_addr,
  output logic [BR_DW-1:0]    wr_data,
  output logic                frame_done,
  output logic                geom_err
);

  localparam int BB = BBIT_B;
  localparam int BE = bbit_e(C_IMG_HW);
  localparam int TB = tbit_b(C_IMG_HW);
  localparam int TE = tbit_e(C_IMG_HW);
  localparam int VB = vbit(C_IMG_HW);
  localparam logic [C_IMG_WW-1:0] W_ONE = 1;
  localparam logic [C_IMG_HW-1:0] H_ONE = 1;

  fsa_state_t state_q, state_d;

  logic [C_IMG_WW-1:0] x_q, width_q, lft_q, rt_q;
  logic [C_IMG_HW-1:0] y_q, height_q;
  logic [C_IN_DW-1:0]  th_q;
  logic                geom_err_q;

  logic                p1_v_q, p1_fg_q, p1_last_q;
  logic [C_IMG_WW-1:0] p1_x_q;
  logic [C_IMG_HW-1:0] p1_y_q;
  logic                p2_v_q, p2_fg_q, p2_last_q;
  logic [C_IMG_WW-1:0] p2_x_q;
  logic [C_IMG_HW-1:0] p2_y_q;
  logic                wr_en_q, wr_last_q, done_q;
  logic [C_IMG_WW-1:0] wr_addr_q;
  logic [BR_DW-1:0]    wr_data_q;

  logic                accept, sof, beatUse, endCol, endRow, fg, lastBeat;
  logic [C_IMG_WW-1:0] curX, effW, effL, effR;
  logic [C_IMG_HW-1:0] curY, effH;
  logic [C_IN_DW-1:0]  effTh;
  logic [BR_DW-1:0]    merged;
  logic                oldVal;

  // Ready drops during reset and while the last writes of a frame drain.
  assign s_axis.tready = !rst && (state_q != FLUSH);
  assign accept  = s_axis.tvalid && s_axis.tready;
  assign sof     = accept && s_axis.tuser;
  assign beatUse = sof || (accept && (state_q == RUN));

  // A start-of-frame beat is pixel (0,0) and uses the live geometry inputs,
  // since the sampled copies only become visible on the next cycle.
  assign curX  = sof ? '0 : x_q;
  assign curY  = sof ? '0 : y_q;
  assign effW  = sof ? width  : width_q;
  assign effH  = sof ? height : height_q;
  assign effL  = sof ? lft_v  : lft_q;
  assign effR  = sof ? rt_v   : rt_q;
  assign effTh = sof ? th     : th_q;

  assign endCol   = (curX == effW - W_ONE);
  assign endRow   = (curY == effH - H_ONE);
  assign fg       = (s_axis.tdata >= effTh) && (effL <= curX) && (curX <= effR);
  assign lastBeat = beatUse && endCol && endRow;

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: SOF starts a frame, the final pixel drains the
  // pipeline, and the final write returns to idle as frame_done fires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sof) state_d = RUN;
      RUN:     if (lastBeat) state_d = FLUSH;
      FLUSH:   if (wr_en_q && wr_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Position counters, geometry capture and the sticky tlast checker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      width_q    <= '0;
      height_q   <= '0;
      lft_q      <= '0;
      rt_q       <= '0;
      th_q       <= '0;
      geom_err_q <= 1'b0;
    end else begin
      if (sof) begin
        width_q  <= width;
        height_q <= height;
        lft_q    <= lft_v;
        rt_q     <= rt_v;
        th_q     <= th;
      end
      if (beatUse) begin
        if (endCol) begin
          x_q <= '0;
          y_q <= endRow ? '0 : curY + H_ONE;
        end else begin
          x_q <= curX + W_ONE;
          y_q <= curY;
        end
        geom_err_q <= (sof ? 1'b0 : geom_err_q) | (s_axis.tlast != endCol);
      end
    end
  end

  // Merge the stored column word with the current pixel; on row 0 the stored
  // word is stale from an earlier frame and is treated as empty.
  always_comb begin
    merged = '0;
    oldVal = rd_data[VB] && (p2_y_q != '0);
    if (p2_fg_q) begin
      merged[VB]    = 1'b1;
      merged[TE:TB] = oldVal ? rd_data[TE:TB] : p2_y_q;
      merged[BE:BB] = p2_y_q;
    end else if (p2_y_q != '0) begin
      merged[VB:0] = rd_data[VB:0];
    end
  end

  // Read-modify-write pipeline: read issue, read return, write issue, done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_v_q    <= 1'b0;
      p1_fg_q   <= 1'b0;
      p1_last_q <= 1'b0;
      p1_x_q    <= '0;
      p1_y_q    <= '0;
      p2_v_q    <= 1'b0;
      p2_fg_q   <= 1'b0;
      p2_last_q <= 1'b0;
      p2_x_q    <= '0;
      p2_y_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_last_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      p1_v_q    <= beatUse;
      p1_fg_q   <= fg;
      p1_last_q <= lastBeat;
      p1_x_q    <= curX;
      p1_y_q    <= curY;
      p2_v_q    <= p1_v_q;
      p2_fg_q   <= p1_fg_q;
      p2_last_q <= p1_v_q && p1_last_q;
      p2_x_q    <= p1_x_q;
      p2_y_q    <= p1_y_q;
      wr_en_q   <= p2_v_q;
      wr_last_q <= p2_v_q && p2_last_q;
      wr_addr_q <= p2_x_q;
      wr_data_q <= merged;
      done_q    <= wr_en_q && wr_last_q;
    end
  end

  generate
    if (BR_DW > VB + 1) begin : g_spare
      logic unusedRdBits;
      assign unusedRdBits = ^rd_data[BR_DW-1:VB+1];
    end
  endgenerate

  assign rd_en      = p1_v_q;
  assign rd_addr    = p1_x_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign geom_err   = geom_err_q;

endmodule
